// File: rtl/dot_product_seq_ctrl_if.sv
// Handshake bundle for the dot-product sequencer: start/busy control,
// chunk operand stream (in_*, a_in, b_in) and result port (out_*, res).
interface dot_product_seq_ctrl_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  logic                        start;
  logic [CNT_W-1:0]            num_chunks;
  logic                        busy;
  logic                        in_valid;
  logic                        in_ready;
  logic [DEPTH-1:0][7:0]       a_in;
  logic [DEPTH-1:0][7:0]       b_in;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [31:0]          res;

  modport master (
    output start, num_chunks, in_valid,
    output a_in, b_in, out_ready,
    input  busy, in_ready, out_valid, res
  );

  modport slave (
    input  start, num_chunks, in_valid,
    input  a_in, b_in, out_ready,
    output busy, in_ready, out_valid, res
  );
endinterface

// File: rtl/dot_product_seq_ctrl.sv
// Sequencer streaming num_chunks x DEPTH operand pairs through one
// dot-product datapath. Ports: clk, rst (async high), bus (slave side).
module dot_product_seq_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  dot_product_seq_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]         state;
  logic signed [31:0] acc;
  logic signed [31:0] res_q;
  logic [CNT_W-1:0]   remaining;
  logic signed [31:0] dp;
  logic signed [16:0] prod [DEPTH];

  // a is unsigned, b signed: zero-extend a so the multiply stays signed.
  always_comb begin
    dp = '0;
    for (int i = 0; i < DEPTH; i++) begin
      prod[i] = 17'($signed({1'b0, bus.a_in[i]}))
              * 17'($signed(bus.b_in[i]));
      dp = dp + 32'(prod[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      res_q     <= '0;
      remaining <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (bus.start) begin
            if (bus.num_chunks != '0) begin
              remaining <= bus.num_chunks;
              acc       <= '0;
              state     <= ACCUM;
            end else begin
              res_q <= '0;
              state <= DONE;
            end
          end
        end
        (state == ACCUM): begin
          if (bus.in_valid) begin
            acc       <= acc + dp;
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              res_q <= acc + dp;
              state <= DONE;
            end
          end
        end
        (state == DONE): begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == DONE);
  assign bus.res       = res_q;

endmodule

// File: tb/tb_dot_product_seq_ctrl.sv
// Self-checking bench for dot_product_seq_ctrl: vector table plus
// random vectors, expected sums queued at start, popped at result.
module tb_dot_product_seq_ctrl;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dot_product_seq_ctrl_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  dot_product_seq_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef logic [3:0][3:0][7:0] blk_t;

  typedef struct {
    logic [15:0]        n;
    blk_t               a;
    blk_t               b;
    int                 stall;
    int                 bp;
    logic signed [31:0] exp;
  } vec_t;

  vec_t               tbl [6];
  logic signed [31:0] sb [$];
  int                 n_chk  = 0;
  int                 n_fail = 0;

  task automatic chk(input string name,
                     input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [31:0] model(
    input logic [15:0] n, input blk_t a, input blk_t b);
    int s = 0;
    for (int c = 0; c < int'(n); c++)
      for (int l = 0; l < DEPTH; l++)
        s += int'(a[c][l]) * int'($signed(b[c][l]));
    return s;
  endfunction

  task automatic run_vec(input vec_t v);
    chk("idle_busy", {31'd0, bus.busy}, 0);
    bus.start      = 1'b1;
    bus.num_chunks = v.n;
    bus.in_valid   = 1'b1;
    bus.a_in       = '1;
    bus.b_in       = '1;
    sb.push_back(v.exp);
    @(negedge clk);
    bus.start      = 1'b0;
    bus.num_chunks = 16'($urandom);
    bus.in_valid   = 1'b0;
    chk("busy_start", {31'd0, bus.busy}, 1);
    if (v.n == 0)
      chk("zero_in_ready", {31'd0, bus.in_ready}, 0);
    for (int c = 0; c < int'(v.n); c++) begin
      chk("in_ready", {31'd0, bus.in_ready}, 1);
      chk("ov_accum", {31'd0, bus.out_valid}, 0);
      bus.in_valid = 1'b1;
      bus.a_in     = v.a[c];
      bus.b_in     = v.b[c];
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.a_in     = 32'($urandom);
      bus.b_in     = 32'($urandom);
      if (c < int'(v.n) - 1) begin
        for (int s = 0; s < v.stall; s++) begin
          chk("stall_busy", {31'd0, bus.busy}, 1);
          chk("stall_ov", {31'd0, bus.out_valid}, 0);
          @(negedge clk);
        end
      end
    end
    chk("ov_latency", {31'd0, bus.out_valid}, 1);
    chk("done_in_ready", {31'd0, bus.in_ready}, 0);
    for (int i = 0; i < v.bp; i++) begin
      bus.out_ready = 1'b0;
      bus.start     = (i == 1);
      chk("bp_ov", {31'd0, bus.out_valid}, 1);
      chk("bp_res", bus.res, sb[0]);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    chk("res", bus.res, sb.pop_front());
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    chk("hs_busy", {31'd0, bus.busy}, 0);
    chk("hs_ov", {31'd0, bus.out_valid}, 0);
    chk("res_kept", bus.res, v.exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t r;

    for (int i = 0; i < 6; i++) begin
      tbl[i].n     = '0;
      tbl[i].a     = '0;
      tbl[i].b     = '0;
      tbl[i].stall = 0;
      tbl[i].bp    = 0;
      tbl[i].exp   = 0;
    end
    tbl[0].n    = 1;
    tbl[0].a[0] = {8'd4, 8'd3, 8'd2, 8'd1};
    tbl[0].b[0] = {4{8'd1}};
    tbl[0].exp  = 10;
    tbl[1].n    = 1;
    tbl[1].a[0] = {4{8'd255}};
    tbl[1].b[0] = {4{8'h80}};
    tbl[1].exp  = -130560;
    tbl[2].n     = 3;
    tbl[2].a[0]  = {4{8'd1}};
    tbl[2].b[0]  = {4{8'd2}};
    tbl[2].a[1]  = {4{8'd3}};
    tbl[2].b[1]  = {4{8'hFF}};
    tbl[2].a[2]  = {4{8'd10}};
    tbl[2].b[2]  = {4{8'd1}};
    tbl[2].stall = 2;
    tbl[2].exp   = 36;
    tbl[3].n    = 0;
    tbl[3].exp  = 0;
    tbl[4].n    = 2;
    tbl[4].a[0] = {8'd200, 8'd0, 8'd17, 8'd128};
    tbl[4].b[0] = {8'h9C, 8'd5, 8'hF6, 8'd127};
    tbl[4].a[1] = {4{8'd2}};
    tbl[4].b[1] = {4{8'd3}};
    tbl[4].bp   = 5;
    tbl[4].exp  = -3890;
    tbl[5].n     = 4;
    tbl[5].stall = 1;
    for (int c = 0; c < 4; c++) begin
      tbl[5].a[c] = {4{8'd7}};
      tbl[5].b[c] = {4{8'hFD}};
    end
    tbl[5].exp = -336;

    bus.start      = 1'b0;
    bus.num_chunks = '0;
    bus.in_valid   = 1'b0;
    bus.a_in       = '0;
    bus.b_in       = '0;
    bus.out_ready  = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 0);
    chk("rst_ov", {31'd0, bus.out_valid}, 0);
    chk("rst_res", bus.res, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // abort a 4-chunk vector after 2 beats
    bus.start      = 1'b1;
    bus.num_chunks = 4;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      bus.in_valid = 1'b1;
      bus.a_in     = {4{8'd100}};
      bus.b_in     = {4{8'd100}};
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 0);
    chk("abort_in_ready", {31'd0, bus.in_ready}, 0);
    chk("abort_ov", {31'd0, bus.out_valid}, 0);
    chk("abort_res", bus.res, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec(tbl[0]);

    for (int k = 0; k < 4; k++) begin
      r.n     = 16'($urandom_range(1, 4));
      r.a     = {$urandom, $urandom, $urandom, $urandom};
      r.b     = {$urandom, $urandom, $urandom, $urandom};
      r.stall = $urandom_range(0, 2);
      r.bp    = $urandom_range(0, 3);
      r.exp   = model(r.n, r.a, r.b);
      run_vec(r);
    end

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
